// File: rtl/cursor_select_pkg.sv
// Shared definitions for the cursor/selection block: FSM state encodings and
// the default board dimensions that the board RAM and matcher also use.
package cursor_select_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ONE  = 2'd1,
    ST_PAIR = 2'd2
  } state_t;

  localparam int BOARD_COLS = 8;
  localparam int BOARD_ROWS = 6;

endpackage

// File: rtl/cursor_select_if.sv
// Tile-pair channel from cursor_select to the matcher.
// Handshake: the master raises pair_valid with stable pair coordinates and
// holds both unchanged until a cycle in which pair_valid && pair_ready; that
// cycle is the transfer. pair_ready while pair_valid is low has no effect.
interface cursor_select_if #(
  parameter int XW = 3,
  parameter int YW = 3
);
  logic          pair_valid;
  logic          pair_ready;
  logic [XW-1:0] pair_x0;
  logic [YW-1:0] pair_y0;
  logic [XW-1:0] pair_x1;
  logic [YW-1:0] pair_y1;

  modport master (
    output pair_valid, pair_x0, pair_y0, pair_x1, pair_y1,
    input  pair_ready
  );

  modport slave (
    input  pair_valid, pair_x0, pair_y0, pair_x1, pair_y1,
    output pair_ready
  );
endinterface

// File: rtl/cursor_select_wrap_ctr.sv
// Up/down modulo-N counter. The wrap is done by explicit compare against the
// end values so non-power-of-2 N never produces an out-of-range count.
module wrap_ctr #(
  parameter int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] MAX = W'(N - 1);

  // Count register; inc wins if both are ever asserted together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= (cnt == MAX) ? '0 : cnt + 1'b1;
    end else if (dec) begin
      cnt <= (cnt == '0) ? MAX : cnt - 1'b1;
    end
  end

endmodule

// File: rtl/cursor_select.sv
// Turns debounced button pulses into cursor moves on a wrapping grid and a
// two-tile selection, offering completed pairs to the matcher.
module cursor_select
  import cursor_select_pkg::*;
#(
  parameter int COLS = BOARD_COLS,
  parameter int ROWS = BOARD_ROWS,
  localparam int XW = $clog2(COLS),
  localparam int YW = $clog2(ROWS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            up_vld,
  input  logic            down_vld,
  input  logic            left_vld,
  input  logic            right_vld,
  input  logic            sel_vld,
  input  logic            tile_empty,
  output logic [XW-1:0]   cur_x,
  output logic [YW-1:0]   cur_y,
  output logic            first_vld,
  output logic [XW-1:0]   first_x,
  output logic [YW-1:0]   first_y,
  output state_t          dbg_state,
  cursor_select_if.master pair_if
);

  state_t        state, state_nxt;
  logic          ld_first, ld_pair;
  logic          mv_up, mv_down, mv_left, mv_right;
  logic          at_first;
  logic [XW-1:0] px0_q, px1_q;
  logic [YW-1:0] py0_q, py1_q;

  // One move per cycle, priority up > down > left > right.
  always_comb begin
    mv_up    = up_vld;
    mv_down  = down_vld & ~up_vld;
    mv_left  = left_vld & ~up_vld & ~down_vld;
    mv_right = right_vld & ~up_vld & ~down_vld & ~left_vld;
  end

  wrap_ctr #(.N(COLS)) u_x_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (mv_right),
    .dec   (mv_left),
    .cnt   (cur_x)
  );

  wrap_ctr #(.N(ROWS)) u_y_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (mv_down),
    .dec   (mv_up),
    .cnt   (cur_y)
  );

  // Select decisions use the cursor before any same-cycle move.
  assign at_first = (cur_x == first_x) && (cur_y == first_y);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and coordinate load strobes; select is ignored in PAIR.
  always_comb begin
    state_nxt = state;
    ld_first  = 1'b0;
    ld_pair   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (sel_vld && !tile_empty) begin
          state_nxt = ST_ONE;
          ld_first  = 1'b1;
        end
      end
      ST_ONE: begin
        if (sel_vld) begin
          if (at_first) begin
            state_nxt = ST_IDLE;
          end else if (!tile_empty) begin
            state_nxt = ST_PAIR;
            ld_pair   = 1'b1;
          end
        end
      end
      ST_PAIR: begin
        if (pair_if.pair_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // First-tile and pair coordinate registers; pair held while offered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_x <= '0;
      first_y <= '0;
      px0_q   <= '0;
      py0_q   <= '0;
      px1_q   <= '0;
      py1_q   <= '0;
    end else begin
      if (ld_first) begin
        first_x <= cur_x;
        first_y <= cur_y;
      end
      if (ld_pair) begin
        px0_q <= first_x;
        py0_q <= first_y;
        px1_q <= cur_x;
        py1_q <= cur_y;
      end
    end
  end

  // Flags decode straight from the state register, so reset clears them
  // asynchronously and no input reaches an output combinationally.
  assign first_vld          = (state != ST_IDLE);
  assign pair_if.pair_valid = (state == ST_PAIR);
  assign pair_if.pair_x0    = px0_q;
  assign pair_if.pair_y0    = py0_q;
  assign pair_if.pair_x1    = px1_q;
  assign pair_if.pair_y1    = py1_q;
  assign dbg_state          = state;

endmodule

// File: tb/tb_cursor_select.sv
// Bench for cursor_select on an 8x6 board: directed vector table, hand-made
// multi-cycle sequences, then random pulses against a reference model.
module tb_cursor_select;
  import cursor_select_pkg::*;

  localparam int COLS = 8;
  localparam int ROWS = 6;

  logic       clk, rst_n;
  logic       up_vld, down_vld, left_vld, right_vld, sel_vld, tile_empty;
  logic [2:0] cur_x, cur_y, first_x, first_y;
  logic       first_vld;
  state_t     dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  cursor_select_if #(.XW(3), .YW(3)) pif ();

  cursor_select #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .up_vld     (up_vld),
    .down_vld   (down_vld),
    .left_vld   (left_vld),
    .right_vld  (right_vld),
    .sel_vld    (sel_vld),
    .tile_empty (tile_empty),
    .cur_x      (cur_x),
    .cur_y      (cur_y),
    .first_vld  (first_vld),
    .first_x    (first_x),
    .first_y    (first_y),
    .dbg_state  (dbg_state),
    .pair_if    (pif.master)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // inputs packed as {up, down, left, right, sel, tile_empty, pair_ready}
  task automatic drive(input logic [6:0] v);
    {up_vld, down_vld, left_vld, right_vld, sel_vld, tile_empty, pif.pair_ready} = v;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [6:0] in;
    int ex, ey;
    logic efv, epv;
    int efx, efy;
  } vec_t;

  vec_t vecs[26];

  // reference model state
  int  mx, my, fx, fy, px0, py0, px1, py1;
  bit  held, offered;
  bit  board[COLS][ROWS];

  task automatic model_step(input bit u, d, l, r, s, te, rdy);
    if (offered) begin
      if (rdy) begin
        offered = 0;
        held    = 0;
      end
    end else if (held) begin
      if (s) begin
        if (mx == fx && my == fy) held = 0;
        else if (!te) begin
          px0 = fx; py0 = fy; px1 = mx; py1 = my;
          offered = 1;
        end
      end
    end else if (s && !te) begin
      held = 1; fx = mx; fy = my;
    end
    if (u)      my = (my + ROWS - 1) % ROWS;
    else if (d) my = (my + 1) % ROWS;
    else if (l) mx = (mx + COLS - 1) % COLS;
    else if (r) mx = (mx + 1) % COLS;
  endtask

  initial begin
    {up_vld, down_vld, left_vld, right_vld, sel_vld, tile_empty, pif.pair_ready} = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cur_x", cur_x, 0);
    chk("rst_cur_y", cur_y, 0);
    chk("rst_first_vld", first_vld, 0);
    chk("rst_pair_valid", pif.pair_valid, 0);
    chk("rst_state", dbg_state, ST_IDLE);
    chk("rst_pair_x0", pif.pair_x0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ---------------- directed vector table ----------------
    for (int i = 0; i < 8; i++) vecs[i] = '{7'b0001000, (i + 1) % 8, 0, 1'b0, 1'b0, 0, 0};
    vecs[8]  = '{7'b1000000, 0, 5, 1'b0, 1'b0, 0, 0};
    vecs[9]  = '{7'b1001000, 0, 4, 1'b0, 1'b0, 0, 0};
    vecs[10] = '{7'b0110000, 0, 5, 1'b0, 1'b0, 0, 0};
    vecs[11] = '{7'b0010000, 7, 5, 1'b0, 1'b0, 0, 0};
    vecs[12] = '{7'b0001000, 0, 5, 1'b0, 1'b0, 0, 0};
    vecs[13] = '{7'b0100000, 0, 0, 1'b0, 1'b0, 0, 0};
    vecs[14] = '{7'b0001100, 1, 0, 1'b1, 1'b0, 0, 0};
    vecs[15] = '{7'b0000110, 1, 0, 1'b1, 1'b0, 0, 0};
    vecs[16] = '{7'b0010000, 0, 0, 1'b1, 1'b0, 0, 0};
    vecs[17] = '{7'b0000100, 0, 0, 1'b0, 1'b0, 0, 0};
    vecs[18] = '{7'b0000110, 0, 0, 1'b0, 1'b0, 0, 0};
    vecs[19] = '{7'b0000100, 0, 0, 1'b1, 1'b0, 0, 0};
    vecs[20] = '{7'b0001000, 1, 0, 1'b1, 1'b0, 0, 0};
    vecs[21] = '{7'b0000100, 1, 0, 1'b1, 1'b1, 0, 0};
    vecs[22] = '{7'b0000100, 1, 0, 1'b1, 1'b1, 0, 0};
    vecs[23] = '{7'b0000101, 1, 0, 1'b0, 1'b0, 0, 0};
    vecs[24] = '{7'b0000001, 1, 0, 1'b0, 1'b0, 0, 0};
    vecs[25] = '{7'b0000000, 1, 0, 1'b0, 1'b0, 0, 0};

    for (int i = 0; i < 26; i++) begin
      drive(vecs[i].in);
      chk($sformatf("vec%0d_cur_x", i), cur_x, vecs[i].ex);
      chk($sformatf("vec%0d_cur_y", i), cur_y, vecs[i].ey);
      chk($sformatf("vec%0d_first_vld", i), first_vld, vecs[i].efv);
      chk($sformatf("vec%0d_pair_valid", i), pif.pair_valid, vecs[i].epv);
      if (vecs[i].efv) begin
        chk($sformatf("vec%0d_first_x", i), first_x, vecs[i].efx);
        chk($sformatf("vec%0d_first_y", i), first_y, vecs[i].efy);
      end
    end

    // ---------------- select then deselect at (2,3) ----------------
    drive(7'b0001000);                       // (2,0)
    repeat (3) drive(7'b0100000);            // (2,3)
    chk("seq_at_x", cur_x, 2);
    chk("seq_at_y", cur_y, 3);
    drive(7'b0000100);
    chk("sel23_first_vld", first_vld, 1);
    chk("sel23_first_x", first_x, 2);
    chk("sel23_first_y", first_y, 3);
    drive(7'b0000100);
    chk("desel23_first_vld", first_vld, 0);
    chk("desel23_state", dbg_state, ST_IDLE);

    // ---------------- pair (1,1)/(4,1) with held-off ready ----------------
    drive(7'b0010000);                       // (1,3)
    repeat (2) drive(7'b1000000);            // (1,1)
    drive(7'b0000100);
    chk("pair_first_vld", first_vld, 1);
    repeat (3) drive(7'b0001000);            // (4,1)
    drive(7'b0000100);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("hold%0d_pair_valid", k), pif.pair_valid, 1);
      chk($sformatf("hold%0d_first_vld", k), first_vld, 1);
      chk($sformatf("hold%0d_pair_x0", k), pif.pair_x0, 1);
      chk($sformatf("hold%0d_pair_y0", k), pif.pair_y0, 1);
      chk($sformatf("hold%0d_pair_x1", k), pif.pair_x1, 4);
      chk($sformatf("hold%0d_pair_y1", k), pif.pair_y1, 1);
      if (k < 5) drive(7'b0000000);
    end
    drive(7'b0000001);
    chk("hs_pair_valid", pif.pair_valid, 0);
    chk("hs_first_vld", first_vld, 0);
    drive(7'b0000000);
    chk("post_hs_pair_valid", pif.pair_valid, 0);

    // ---------------- async reset mid-PAIR ----------------
    drive(7'b0000100);                       // first at (4,1)
    drive(7'b0010000);                       // (3,1)
    drive(7'b0000100);
    chk("pre_rst_pair_valid", pif.pair_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_pair_valid", pif.pair_valid, 0);
    chk("async_rst_first_vld", first_vld, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(7'b0000001);
    chk("after_rst_cur_x", cur_x, 0);
    chk("after_rst_cur_y", cur_y, 0);
    chk("after_rst_pair_valid", pif.pair_valid, 0);
    chk("after_rst_first_vld", first_vld, 0);

    // ---------------- random against reference model ----------------
    mx = 0; my = 0; fx = 0; fy = 0; held = 0; offered = 0;
    px0 = 0; py0 = 0; px1 = 0; py1 = 0;
    for (int x = 0; x < COLS; x++)
      for (int y = 0; y < ROWS; y++)
        board[x][y] = ($urandom_range(0, 3) == 0);
    for (int c = 0; c < 600; c++) begin
      bit u, d, l, r, s, te, rdy;
      u   = ($urandom_range(0, 5) == 0);
      d   = ($urandom_range(0, 5) == 0);
      l   = ($urandom_range(0, 4) == 0);
      r   = ($urandom_range(0, 3) == 0);
      s   = ($urandom_range(0, 2) == 0);
      rdy = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 19) == 0) board[mx][my] = ~board[mx][my];
      te  = board[mx][my];
      drive({u, d, l, r, s, te, rdy});
      model_step(u, d, l, r, s, te, rdy);
      chk("rnd_cur_x", cur_x, mx);
      chk("rnd_cur_y", cur_y, my);
      chk("rnd_first_vld", first_vld, held);
      chk("rnd_pair_valid", pif.pair_valid, offered);
      if (held) begin
        chk("rnd_first_x", first_x, fx);
        chk("rnd_first_y", first_y, fy);
      end
      if (offered) begin
        chk("rnd_pair_x0", pif.pair_x0, px0);
        chk("rnd_pair_y0", pif.pair_y0, py0);
        chk("rnd_pair_x1", pif.pair_x1, px1);
        chk("rnd_pair_y1", pif.pair_y1, py1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
